// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator controller.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_ENTER_A = 2'd0,
        ST_ENTER_B = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    localparam logic [2:0] OPC_ADD = 3'b001;
    localparam logic [2:0] OPC_SUB = 3'b010;
    localparam logic [2:0] OPC_MUL = 3'b100;

    localparam int unsigned DIGIT_MAX = 9;

    function automatic logic opc_valid(input logic [2:0] code);
        return (code == OPC_ADD) || (code == OPC_SUB) || (code == OPC_MUL);
    endfunction

    function automatic op_t opc_decode(input logic [2:0] code);
        op_t op;
        case (code)
            OPC_SUB: op = OP_SUB;
            OPC_MUL: op = OP_MUL;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_mul.sv
// Sequential shift-add multiplier on unsigned magnitudes; one partial product per cycle.
module calc_mul
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]    r_prod;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    // done stays high until the next start or abort
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (abort) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (start) begin
            r_mcand  <= PW'(a);
            r_mplier <= b;
            r_prod   <= '0;
            r_cnt    <= CW'(WIDTH);
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign done    = r_done;
    assign product = r_prod;

endmodule

// File: rtl/calc_ctrl.sv
// Keypad calculator controller: edge-detected entry of two signed decimal
// operands, add/sub/mul with saturation, result chaining and clear.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    nRST,
    input  logic [3:0]              keypad_input,
    input  logic                    read_input,
    input  logic [2:0]              operator_input,
    input  logic                    equal_input,
    input  logic                    neg_input,
    input  logic                    clear_input,
    output logic                    complete,
    output logic                    busy,
    output logic                    overflow,
    output logic signed [WIDTH-1:0] display_output
);

    localparam int unsigned AW = WIDTH + 4;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

    localparam logic [AW-1:0]    POS_LIM = AW'({(WIDTH-1){1'b1}});
    localparam logic [AW-1:0]    NEG_LIM = POS_LIM + AW'(1);
    localparam logic [PW-1:0]    P_POS   = PW'(POS_LIM);
    localparam logic [PW-1:0]    P_NEG   = PW'(NEG_LIM);
    localparam logic [WIDTH-1:0] RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    op_t              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_mag;
    logic             r_neg;
    logic [CW-1:0]    r_ndig;
    logic [WIDTH-1:0] r_disp;
    logic             r_complete;
    logic             r_busy;
    logic             r_ovf;

    logic             r_prev_read;
    logic [2:0]       r_prev_op;
    logic             r_prev_eq;
    logic             r_prev_neg;
    logic             r_prev_clr;

    logic             w_ev_read, w_ev_op, w_ev_eq, w_ev_neg, w_ev_clr;
    logic             w_clr, w_eq, w_opk, w_dig, w_neg;
    op_t              w_op_dec;
    logic [WIDTH-1:0] w_acc;
    logic [AW-1:0]    w_new_mag;
    logic [WIDTH-1:0] w_acc_dig;
    logic             w_key_ok;
    logic             w_digit_ok;
    logic             w_neg_ok;
    logic [WIDTH-1:0] w_mag_a;
    logic             w_mul_start;
    logic             w_mul_done;
    logic [PW-1:0]    w_prod;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_res_ovf;

    // Rising-edge events, then the priority filter: one event per edge at most
    always_comb begin
        w_ev_read = read_input & ~r_prev_read;
        w_ev_op   = opc_valid(operator_input) && (r_prev_op == 3'b000);
        w_ev_eq   = equal_input & ~r_prev_eq;
        w_ev_neg  = neg_input & ~r_prev_neg;
        w_ev_clr  = clear_input & ~r_prev_clr;

        w_clr = w_ev_clr;
        w_eq  = w_ev_eq & ~w_ev_clr;
        w_opk = w_ev_op & ~w_ev_eq & ~w_ev_clr;
        w_dig = w_ev_read & ~w_ev_op & ~w_ev_eq & ~w_ev_clr;
        w_neg = w_ev_neg & ~w_ev_read & ~w_ev_op & ~w_ev_eq & ~w_ev_clr;
        w_op_dec = opc_decode(operator_input);
    end

    // Operand entry kept as sign + magnitude so the range check is symmetric
    always_comb begin
        w_acc      = r_neg ? ('0 - r_mag) : r_mag;
        w_new_mag  = AW'(r_mag) * AW'(10) + AW'(keypad_input);
        w_acc_dig  = r_neg ? ('0 - WIDTH'(w_new_mag)) : WIDTH'(w_new_mag);
        w_key_ok   = keypad_input <= 4'(DIGIT_MAX);
        w_digit_ok = w_key_ok && (r_ndig < CW'(MAX_DIGITS)) &&
                     (w_new_mag <= (r_neg ? NEG_LIM : POS_LIM));
        w_neg_ok   = !(r_neg && (AW'(r_mag) == NEG_LIM));
        w_mag_a    = r_a[WIDTH-1] ? ('0 - r_a) : r_a;
    end

    assign w_mul_start = (r_state == ST_ENTER_B) && w_eq && (r_op == OP_MUL);

    calc_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .nRST    (nRST),
        .start   (w_mul_start),
        .abort   (w_clr),
        .a       (w_mag_a),
        .b       (r_mag),
        .done    (w_mul_done),
        .product (w_prod)
    );

    // Result and saturation for the operation latched in r_op
    always_comb begin
        w_res     = '0;
        w_res_ovf = 1'b0;
        w_sum     = (r_op == OP_SUB) ? ({r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b})
                                     : ({r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b});
        if (r_op == OP_MUL) begin
            if (!(r_a[WIDTH-1] ^ r_b[WIDTH-1])) begin
                if (w_prod > P_POS) begin
                    w_res     = RES_MAX;
                    w_res_ovf = 1'b1;
                end else begin
                    w_res = WIDTH'(w_prod);
                end
            end else begin
                if (w_prod > P_NEG) begin
                    w_res     = RES_MIN;
                    w_res_ovf = 1'b1;
                end else begin
                    w_res = WIDTH'(PW'(0) - w_prod);
                end
            end
        end else if (w_sum[WIDTH] != w_sum[WIDTH-1]) begin
            w_res     = w_sum[WIDTH] ? RES_MIN : RES_MAX;
            w_res_ovf = 1'b1;
        end else begin
            w_res = w_sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state     <= ST_ENTER_A;
            r_op        <= OP_ADD;
            r_a         <= '0;
            r_b         <= '0;
            r_mag       <= '0;
            r_neg       <= 1'b0;
            r_ndig      <= '0;
            r_disp      <= '0;
            r_complete  <= 1'b0;
            r_busy      <= 1'b0;
            r_ovf       <= 1'b0;
            r_prev_read <= 1'b0;
            r_prev_op   <= '0;
            r_prev_eq   <= 1'b0;
            r_prev_neg  <= 1'b0;
            r_prev_clr  <= 1'b0;
        end else begin
            r_prev_read <= read_input;
            r_prev_op   <= operator_input;
            r_prev_eq   <= equal_input;
            r_prev_neg  <= neg_input;
            r_prev_clr  <= clear_input;

            if (w_clr) begin
                r_state    <= ST_ENTER_A;
                r_op       <= OP_ADD;
                r_a        <= '0;
                r_b        <= '0;
                r_mag      <= '0;
                r_neg      <= 1'b0;
                r_ndig     <= '0;
                r_disp     <= '0;
                r_complete <= 1'b0;
                r_busy     <= 1'b0;
                r_ovf      <= 1'b0;
            end else begin
                case (r_state)
                    ST_ENTER_A: begin
                        if (w_opk) begin
                            r_a     <= w_acc;
                            r_op    <= w_op_dec;
                            r_mag   <= '0;
                            r_neg   <= 1'b0;
                            r_ndig  <= '0;
                            r_state <= ST_ENTER_B;
                        end else if (w_dig && w_digit_ok) begin
                            r_mag  <= WIDTH'(w_new_mag);
                            r_ndig <= r_ndig + CW'(1);
                            r_disp <= w_acc_dig;
                        end else if (w_neg && w_neg_ok) begin
                            r_neg  <= ~r_neg;
                            r_disp <= '0 - w_acc;
                        end
                    end
                    ST_ENTER_B: begin
                        if (w_eq) begin
                            r_b     <= w_acc;
                            r_busy  <= 1'b1;
                            r_state <= ST_COMPUTE;
                        end else if (w_opk) begin
                            // Operator may be corrected only before any B digit
                            if (r_ndig == '0) begin
                                r_op <= w_op_dec;
                            end
                        end else if (w_dig && w_digit_ok) begin
                            r_mag  <= WIDTH'(w_new_mag);
                            r_ndig <= r_ndig + CW'(1);
                            r_disp <= w_acc_dig;
                        end else if (w_neg && w_neg_ok) begin
                            r_neg  <= ~r_neg;
                            r_disp <= '0 - w_acc;
                        end
                    end
                    ST_COMPUTE: begin
                        if ((r_op != OP_MUL) || w_mul_done) begin
                            r_disp     <= w_res;
                            r_ovf      <= w_res_ovf;
                            r_busy     <= 1'b0;
                            r_complete <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (w_opk) begin
                            r_a        <= r_disp;
                            r_op       <= w_op_dec;
                            r_mag      <= '0;
                            r_neg      <= 1'b0;
                            r_ndig     <= '0;
                            r_complete <= 1'b0;
                            r_state    <= ST_ENTER_B;
                        end else if (w_dig && w_key_ok) begin
                            r_mag      <= WIDTH'(keypad_input);
                            r_neg      <= 1'b0;
                            r_ndig     <= CW'(1);
                            r_disp     <= WIDTH'(keypad_input);
                            r_ovf      <= 1'b0;
                            r_complete <= 1'b0;
                            r_state    <= ST_ENTER_A;
                        end
                    end
                    default: r_state <= ST_ENTER_A;
                endcase
            end
        end
    end

    assign complete       = r_complete;
    assign busy           = r_busy;
    assign overflow       = r_ovf;
    assign display_output = r_disp;

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Parametrised, sequential calculator controller: the next generation of the 16-bit signed gencon keypad controller. It accumulates decimal keypad digits into two signed operands and applies add, subtract or multiply on equal. The multiply is sequential and the result saturates. It adds result chaining, sign toggle, clear, an overflow flag and edge-detected inputs. It sits between the keypad/button debouncers and the display driver.

## Interface
- WIDTH, 16: operand/result width, two's complement.
- MAX_DIGITS, 5: maximum decimal digits accepted per operand.
- clk  in  1  system clock; all state updates on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- keypad_input  in  4  digit value; 0–9 valid, 10–15 ignored.
- read_input  in  1  digit strobe; level, edge-detected internally.
- operator_input  in  3  one-hot: 001 add, 010 sub, 100 mul; any other code ignored; edge-detected (0→valid code).
- equal_input  in  1  evaluate; edge-detected.
- neg_input  in  1  toggle sign of operand being entered; edge-detected.
- clear_input  in  1  synchronous clear to ENTER_A; edge-detected.
- complete  out  1  high while in DONE.
- busy  out  1  high while in COMPUTE.
- overflow  out  1  last result saturated; valid with complete.
- display_output  out  WIDTH  signed; current entry or result.

## Operation
- Event = input sampled high at a clock edge while its registered previous sample was low. Holding a level for N cycles gives exactly one event.
- Priority for same-edge events: clear > equal > operator > digit > neg. Lower-priority events on that edge are dropped.
- States: ENTER_A, ENTER_B, COMPUTE, DONE.
- ENTER_A:
  - digit: acc = acc*10 + d with the sign applied. Ignored if MAX_DIGITS digits are already entered or the result would leave the signed WIDTH range.
  - neg: toggles the sign; the display shows −acc.
  - operator: A = acc, op latched, clear acc, go to ENTER_B.
  - equal: ignored.
- ENTER_B:
  - digit and neg: as in ENTER_A, applied to B.
  - operator: replaces op only if no B digit has been entered; otherwise ignored.
  - equal: B = acc (0 if no digits), go to COMPUTE.
- COMPUTE: all inputs except clear are ignored.
  - Add/sub: exact result computed in WIDTH+1 bits.
  - Mul: unsigned shift-add on magnitudes for WIDTH cycles, then sign applied.
  - Result outside [−2^(WIDTH−1), 2^(WIDTH−1)−1] saturates to the nearest bound and sets overflow=1.
  - Then go to DONE.
- DONE:
  - operator: A = result, op latched, go to ENTER_B (chaining).
  - digit: start a fresh ENTER_A with that digit and clear overflow.
  - neg: ignored. equal: ignored.
- clear, in any state: acc, A, B, op and overflow are cleared, display=0, go to ENTER_A. Clear during COMPUTE aborts the multiplier.
- nRST low at any time, including mid-multiply: immediate return to reset state.
- Reset values: ENTER_A; display_output=0, complete=0, busy=0, overflow=0; edge-detect registers=0.

## Timing
- Event sampled at edge k → state, acc and display_output updated at edge k (registered outputs, visible after k).
- Equal event at edge k: COMPUTE entered at k, busy=1.
- Add/sub: result, complete=1 and busy=0 after edge k+1.
- Mul: busy for WIDTH+1 cycles; result and complete=1 after edge k+WIDTH+1.
- complete falls at the edge that leaves DONE.
- display_output updates only on accepted events and on the result write.

## Structure
- Package calc_pkg holds:
  - state_t enum
  - op_t enum (OP_ADD, OP_SUB, OP_MUL)
  - one-hot decode constants 3'b001/3'b010/3'b100
  - DIGIT_MAX=9
- Sub-module calc_mul: WIDTH-parameterised sequential shift-add multiplier.
  - Ports: clk, nRST, start, abort, a, b (unsigned magnitudes), done, product[2*WIDTH].
- Everything else stays in calc_ctrl: edge detect, digit accumulation, FSM, saturation.

## Test plan
- 12 + 34 = → display 46, complete after 2 cycles from the equal edge, overflow 0. Then reset, 15 − 7 = → 8.
- 123 × 45 = → busy for 17 cycles (WIDTH=16), then display 5535, complete=1.
- 200 × 200 = → 32767, overflow=1. Then −30000 − 5000 = (neg before digits) → −32768, overflow=1.
- Chaining: 12 + 3 = (15), then sub, 20, = → −5. read_input held 3 cycles on digit 7 → a single 7 accepted. A 6th digit is ignored.
- Clear asserted mid-multiply → busy=0 and display=0 next cycle, state ENTER_A. nRST pulsed mid-entry → all outputs at reset values.
- Same-edge equal and digit in ENTER_B → equal wins and the digit is dropped. An invalid operator code 011 is ignored.
